mpmc10_rd_data_capture: RTL and testbench

Read-return side of the MIG application interface, the counterpart to the write-data strobe path. Records a port tag for each read command the MIG accepts. Assembles app_rd_data beats into full lines and hands each line, with its tag, to the port-return logic over a valid/ready handshake. The MIG read path cannot be back-pressured, so the block meters command issue with credits and flags protocol violations.

---
 rtl/mpmc10_rd_data_capture.sv | 222 ++++++++++++++++++++++
 tb/tb_mpmc10_rd_data_capture.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mpmc10_rd_data_capture.sv
// MIG read-return capture: tags each issued read, assembles app_rd_data beats into lines,
// and presents lines with their tags over valid/ready. Optional read timeout: MPMC10_RD_TIMEOUT_EN.
module mpmc10_rd_data_capture #(
    parameter int unsigned DW    = 128,
    parameter int unsigned BEATS = 2,
    parameter int unsigned TAGW  = 4,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TMO   = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_issue,
    input  logic [TAGW-1:0]            cmd_tag,
    input  logic                       rd_data_valid,
    input  logic                       rd_data_end,
    input  logic [DW-1:0]              rd_data,
    output logic [DW*BEATS-1:0]        line_o,
    output logic [TAGW-1:0]            line_tag_o,
    output logic                       line_valid_o,
    input  logic                       line_ready_i,
    output logic                       credit_full_o,
    output logic [$clog2(DEPTH):0]     inflight_o,
    output logic [4:0]                 err_o,
    input  logic                       err_clr_i
);

    localparam int unsigned LW = DW * BEATS;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {CAP_IDLE = 1'b0, CAP_BEAT = 1'b1} cap_state_t;

    cap_state_t        state;
    logic [BW-1:0]     beat_cnt;
    logic [LW-1:0]     line_buf;
    logic [LW-1:0]     line_asm_c;

    logic [TAGW-1:0]   tag_mem [DEPTH];
    logic [AW-1:0]     tag_wr;
    logic [AW-1:0]     tag_rd;
    logic [CW-1:0]     tag_cnt;

    logic [LW-1:0]     slot_line;
    logic [TAGW-1:0]   slot_tag;
    logic              slot_valid;

    logic              issue_ok_c;
    logic              issue_err_c;
    logic              tag_empty_c;
    logic              beat_last_c;
    logic              beat_take_c;
    logic              orphan_c;
    logic              done_c;
    logic              end_err_c;
    logic              pop_out_c;
    logic              drop_c;
    logic              tmo_hit_c;
    logic              tag_pop_c;
    logic [CW-1:0]     inflight_nxt_c;

    // Event decode for the current cycle.
    always_comb begin
        issue_ok_c  = cmd_issue & ~credit_full_o;
        issue_err_c = cmd_issue & credit_full_o;
        tag_empty_c = (tag_cnt == '0);
        beat_last_c = 1'b0;
        if (BEATS == 1) begin
            beat_last_c = 1'b1;
        end else begin
            beat_last_c = (state == CAP_BEAT) && (beat_cnt == BW'(BEATS - 1));
        end
        beat_take_c = rd_data_valid & ((state == CAP_BEAT) | ~tag_empty_c);
        orphan_c    = rd_data_valid & (state == CAP_IDLE) & tag_empty_c;
        done_c      = beat_take_c & beat_last_c;
        end_err_c   = beat_take_c & (rd_data_end != beat_last_c);
        pop_out_c   = line_valid_o & line_ready_i;
        drop_c      = done_c & line_valid_o & slot_valid & ~pop_out_c;
        tag_pop_c   = done_c | tmo_hit_c;
        inflight_nxt_c = inflight_o + CW'(issue_ok_c) - CW'(pop_out_c)
                       - CW'(drop_c) - CW'(tmo_hit_c);
    end

    // Completed line: captured beats plus the final beat straight off the bus.
    always_comb begin
        line_asm_c = line_buf;
        line_asm_c[LW-DW +: DW] = rd_data;
    end

`ifdef MPMC10_RD_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TMO + 1);
    logic [TW-1:0] tmo_cnt;

    assign tmo_hit_c = ~tag_empty_c & ~rd_data_valid & (tmo_cnt == TW'(TMO));

    // Cycles since the oldest outstanding read last saw data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (tag_empty_c | rd_data_valid | tmo_hit_c) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end
`else
    assign tmo_hit_c = 1'b0;
`endif

    // Tag storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (issue_ok_c) begin
            tag_mem[tag_wr] <= cmd_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_wr  <= '0;
            tag_rd  <= '0;
            tag_cnt <= '0;
        end else begin
            if (issue_ok_c) begin
                tag_wr <= (tag_wr == AW'(DEPTH - 1)) ? '0 : tag_wr + AW'(1);
            end
            if (tag_pop_c) begin
                tag_rd <= (tag_rd == AW'(DEPTH - 1)) ? '0 : tag_rd + AW'(1);
            end
            tag_cnt <= tag_cnt + CW'(issue_ok_c) - CW'(tag_pop_c);
        end
    end

    // Beat capture FSM; the counter, not rd_data_end, decides where a line ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CAP_IDLE;
            beat_cnt <= '0;
            line_buf <= '0;
        end else begin
            case (state)
                CAP_IDLE: begin
                    if (beat_take_c && (BEATS > 1)) begin
                        line_buf[DW-1:0] <= rd_data;
                        beat_cnt         <= BW'(1);
                        state            <= CAP_BEAT;
                    end
                end
                CAP_BEAT: begin
                    if (tmo_hit_c) begin
                        beat_cnt <= '0;
                        state    <= CAP_IDLE;
                    end else if (rd_data_valid) begin
                        line_buf[int'(beat_cnt)*DW +: DW] <= rd_data;
                        if (beat_last_c) begin
                            beat_cnt <= '0;
                            state    <= CAP_IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + BW'(1);
                        end
                    end
                end
                default: begin
                    beat_cnt <= '0;
                    state    <= CAP_IDLE;
                end
            endcase
        end
    end

    // Two-entry output queue: head drives the outputs directly, slot is the spare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_o       <= '0;
            line_tag_o   <= '0;
            line_valid_o <= 1'b0;
            slot_line    <= '0;
            slot_tag     <= '0;
            slot_valid   <= 1'b0;
        end else if (pop_out_c) begin
            if (slot_valid) begin
                line_o     <= slot_line;
                line_tag_o <= slot_tag;
                if (done_c) begin
                    slot_line <= line_asm_c;
                    slot_tag  <= tag_mem[tag_rd];
                end else begin
                    slot_valid <= 1'b0;
                end
            end else if (done_c) begin
                line_o     <= line_asm_c;
                line_tag_o <= tag_mem[tag_rd];
            end else begin
                line_valid_o <= 1'b0;
            end
        end else if (done_c) begin
            if (!line_valid_o) begin
                line_o       <= line_asm_c;
                line_tag_o   <= tag_mem[tag_rd];
                line_valid_o <= 1'b1;
            end else if (!slot_valid) begin
                slot_line  <= line_asm_c;
                slot_tag   <= tag_mem[tag_rd];
                slot_valid <= 1'b1;
            end
        end
    end

    // Credit accounting and sticky errors; a fresh error beats a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_o    <= '0;
            credit_full_o <= 1'b0;
            err_o         <= '0;
        end else begin
            inflight_o    <= inflight_nxt_c;
            credit_full_o <= (inflight_nxt_c == CW'(DEPTH));
            err_o         <= (err_clr_i ? 5'b0 : err_o)
                           | {tmo_hit_c, issue_err_c, drop_c, end_err_c, orphan_c};
        end
    end

endmodule

// File: tb/tb_mpmc10_rd_data_capture.sv
// Directed bench for mpmc10_rd_data_capture (DW=8, BEATS=2, TAGW=4, DEPTH=8, TMO=15).
module tb_mpmc10_rd_data_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_issue = 1'b0;
    logic [3:0]  cmd_tag = '0;
    logic        rd_data_valid = 1'b0;
    logic        rd_data_end = 1'b0;
    logic [7:0]  rd_data = '0;
    logic [15:0] line_o;
    logic [3:0]  line_tag_o;
    logic        line_valid_o;
    logic        line_ready_i = 1'b0;
    logic        credit_full_o;
    logic [3:0]  inflight_o;
    logic [4:0]  err_o;
    logic        err_clr_i = 1'b0;

    int total = 0;
    int bad   = 0;

    mpmc10_rd_data_capture #(.DW(8), .BEATS(2), .TAGW(4), .DEPTH(8), .TMO(15)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_issue     (cmd_issue),
        .cmd_tag       (cmd_tag),
        .rd_data_valid (rd_data_valid),
        .rd_data_end   (rd_data_end),
        .rd_data       (rd_data),
        .line_o        (line_o),
        .line_tag_o    (line_tag_o),
        .line_valid_o  (line_valid_o),
        .line_ready_i  (line_ready_i),
        .credit_full_o (credit_full_o),
        .inflight_o    (inflight_o),
        .err_o         (err_o),
        .err_clr_i     (err_clr_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iss;
        logic [3:0]  tag;
        logic        rdv;
        logic        rend;
        logic [7:0]  d;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [15:0] el;
        logic [3:0]  et;
        logic [3:0]  ei;
        logic        ef;
        logic [4:0]  ee;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(input logic iss, input logic [3:0] tag, input logic rdv,
                                input logic rend, input logic [7:0] d, input logic rdy,
                                input logic clr, input logic ev, input logic [15:0] el,
                                input logic [3:0] et, input logic [3:0] ei, input logic ef,
                                input logic [4:0] ee);
        vec_t v;
        v.iss = iss; v.tag = tag; v.rdv = rdv; v.rend = rend; v.d = d; v.rdy = rdy;
        v.clr = clr; v.ev = ev; v.el = el; v.et = et; v.ei = ei; v.ef = ef; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic iss, input logic [3:0] tg, input logic v, input logic e,
                       input logic [7:0] d, input logic rdy, input logic clr);
        cmd_issue = iss; cmd_tag = tg; rd_data_valid = v; rd_data_end = e;
        rd_data = d; line_ready_i = rdy; err_clr_i = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cmd_issue = 1'b0; rd_data_valid = 1'b0; rd_data_end = 1'b0;
        line_ready_i = 1'b0; err_clr_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // iss tag rdv end data rdy clr | valid line tag inflight full err
        tbl[0]  = mk(1, 4'h5, 0, 0, 8'h00, 0, 0,  0, 16'h0000, 4'h0, 4'd1, 0, 5'h00);
        tbl[1]  = mk(1, 4'h9, 0, 0, 8'h00, 0, 0,  0, 16'h0000, 4'h0, 4'd2, 0, 5'h00);
        tbl[2]  = mk(0, 4'h0, 1, 0, 8'h11, 0, 0,  0, 16'h0000, 4'h0, 4'd2, 0, 5'h00);
        tbl[3]  = mk(0, 4'h0, 1, 1, 8'h22, 0, 0,  1, 16'h2211, 4'h5, 4'd2, 0, 5'h00);
        tbl[4]  = mk(0, 4'h0, 1, 0, 8'h33, 0, 0,  1, 16'h2211, 4'h5, 4'd2, 0, 5'h00);
        tbl[5]  = mk(0, 4'h0, 1, 1, 8'h44, 1, 0,  1, 16'h4433, 4'h9, 4'd1, 0, 5'h00);
        tbl[6]  = mk(0, 4'h0, 0, 0, 8'h00, 1, 0,  0, 16'h0000, 4'h0, 4'd0, 0, 5'h00);
        tbl[7]  = mk(0, 4'h0, 0, 0, 8'h00, 0, 0,  0, 16'h0000, 4'h0, 4'd0, 0, 5'h00);
        tbl[8]  = mk(1, 4'h1, 0, 0, 8'h00, 0, 0,  0, 16'h0000, 4'h0, 4'd1, 0, 5'h00);
        tbl[9]  = mk(0, 4'h0, 1, 1, 8'h55, 0, 0,  0, 16'h0000, 4'h0, 4'd1, 0, 5'h02);
        tbl[10] = mk(0, 4'h0, 1, 1, 8'h66, 0, 0,  1, 16'h6655, 4'h1, 4'd1, 0, 5'h02);
        tbl[11] = mk(0, 4'h0, 0, 0, 8'h00, 0, 1,  1, 16'h6655, 4'h1, 4'd1, 0, 5'h00);
        tbl[12] = mk(1, 4'h2, 0, 0, 8'h00, 1, 0,  0, 16'h0000, 4'h0, 4'd1, 0, 5'h00);
        tbl[13] = mk(0, 4'h0, 1, 0, 8'h77, 0, 0,  0, 16'h0000, 4'h0, 4'd1, 0, 5'h00);
        tbl[14] = mk(0, 4'h0, 1, 0, 8'h88, 0, 0,  1, 16'h8877, 4'h2, 4'd1, 0, 5'h02);
        tbl[15] = mk(0, 4'h0, 0, 0, 8'h00, 1, 0,  0, 16'h0000, 4'h0, 4'd0, 0, 5'h02);
        tbl[16] = mk(0, 4'h0, 1, 1, 8'h99, 0, 0,  0, 16'h0000, 4'h0, 4'd0, 0, 5'h03);
        tbl[17] = mk(0, 4'h0, 1, 0, 8'hAA, 0, 1,  0, 16'h0000, 4'h0, 4'd0, 0, 5'h01);
        tbl[18] = mk(0, 4'h0, 0, 0, 8'h00, 0, 1,  0, 16'h0000, 4'h0, 4'd0, 0, 5'h00);

        do_reset();
        chk("reset_state", {19'b0, line_valid_o, inflight_o, credit_full_o, err_o},
            {19'b0, 1'b0, 4'd0, 1'b0, 5'h00});

        // Main table: in-order lines, stall hold, end misalignment, orphans, clear priority.
        for (int i = 0; i < 19; i++) begin
            logic [31:0] act;
            logic [31:0] exp;
            cyc(tbl[i].iss, tbl[i].tag, tbl[i].rdv, tbl[i].rend, tbl[i].d, tbl[i].rdy, tbl[i].clr);
            act = {1'b0, line_valid_o, (line_valid_o ? line_o : 16'h0),
                   (line_valid_o ? line_tag_o : 4'h0), inflight_o, credit_full_o, err_o};
            exp = {1'b0, tbl[i].ev, tbl[i].el, tbl[i].et, tbl[i].ei, tbl[i].ef, tbl[i].ee};
            if (act !== exp) begin
                bad++;
                $display("FAIL vec%0d: got 0x%08h expected 0x%08h", i, act, exp);
            end
            total++;
        end
        idle();

        // Reset in the middle of a line, then a beat with no read outstanding.
        do_reset();
        cyc(1'b1, 4'h3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 8'h0A, 1'b0, 1'b0);
        cmd_issue = 1'b0; rd_data_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("midline_reset", {19'b0, line_valid_o, inflight_o, credit_full_o, err_o},
            {19'b0, 1'b0, 4'd0, 1'b0, 5'h00});
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 8'h0B, 1'b0, 1'b0);
        chk("orphan_after_reset", {27'b0, err_o}, {27'b0, 5'h01});
        idle();

        // Output overflow: two lines held, third dropped.
        do_reset();
        for (int t = 1; t <= 3; t++) cyc(1'b1, 4'(t), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int b = 1; b <= 6; b++) cyc(1'b0, 4'h0, 1'b1, 1'(b % 2 == 0), 8'(b), 1'b0, 1'b0);
        chk("ovf_err", {27'b0, err_o}, {27'b0, 5'h04});
        chk("ovf_inflight", {28'b0, inflight_o}, {28'b0, 4'd2});
        chk("ovf_head", {11'b0, line_valid_o, line_o, line_tag_o}, {11'b0, 1'b1, 16'h0201, 4'h1});
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clear", {27'b0, err_o}, {27'b0, 5'h00});
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("ovf_second", {7'b0, line_valid_o, line_o, line_tag_o, inflight_o},
            {7'b0, 1'b1, 16'h0403, 4'h2, 4'd1});
        cyc(1'b0, 4'h0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("ovf_drained", {27'b0, line_valid_o, inflight_o}, {27'b0, 1'b0, 4'd0});
        idle();

        // Credit limit: eight reads fill the credits, a ninth is refused.
        do_reset();
        for (int t = 0; t < 8; t++) cyc(1'b1, 4'(t), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("credit_full", {27'b0, credit_full_o, inflight_o}, {27'b0, 1'b1, 4'd8});
        cyc(1'b1, 4'hF, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("issue_while_full", {22'b0, credit_full_o, inflight_o, err_o},
            {22'b0, 1'b1, 4'd8, 5'h08});
        idle();

        // Same-cycle issue and accept at four in flight.
        do_reset();
        for (int t = 0; t < 4; t++) cyc(1'b1, 4'(t), 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 1'b1, 8'h20, 1'b0, 1'b0);
        chk("four_head", {7'b0, line_valid_o, line_o, line_tag_o, inflight_o},
            {7'b0, 1'b1, 16'h2010, 4'h0, 4'd4});
        cyc(1'b1, 4'h4, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("issue_and_accept", {22'b0, line_valid_o, inflight_o, err_o},
            {22'b0, 1'b0, 4'd4, 5'h00});
        idle();

`ifdef MPMC10_RD_TIMEOUT_EN
        // Timeout flushes a stalled read and its partial line.
        begin
            bit seen;
            seen = 1'b0;
            do_reset();
            cyc(1'b1, 4'h6, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
            cyc(1'b0, 4'h0, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
            for (int c = 0; c < 40 && !seen; c++) begin
                idle();
                seen = err_o[4];
            end
            chk("timeout_seen", {31'b0, seen}, 32'd1);
            chk("timeout_inflight", {28'b0, inflight_o}, {28'b0, 4'd0});
            cyc(1'b1, 4'h7, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
            cyc(1'b0, 4'h0, 1'b1, 1'b0, 8'hC1, 1'b0, 1'b0);
            cyc(1'b0, 4'h0, 1'b1, 1'b1, 8'hC2, 1'b0, 1'b0);
            chk("timeout_recover", {2'b0, err_o, line_valid_o, line_o, line_tag_o},
                {2'b0, 5'h00, 1'b1, 16'hC2C1, 4'h7});
            idle();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
